// File: rtl/gearbox_pkg.sv
// Shared constants for the 64b/66b RX/TX gearboxes and block sync.
package gearbox_pkg;

    localparam int IN_W    = 32;
    localparam int BLOCK_W = 66;
    localparam int BUF_W   = 98;
    localparam int CNT_W   = 7;
    localparam int SLIP_W  = 16;

    typedef enum logic [1:0] {
        HDR_DATA = 2'b01,
        HDR_CTRL = 2'b10
    } hdr_e;

    // A legal sync header has exactly one bit set.
    function automatic logic hdr_valid(input logic [1:0] hdr);
        return hdr[0] ^ hdr[1];
    endfunction

    function automatic logic [SLIP_W-1:0] sat_inc16(input logic [SLIP_W-1:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gearbox_rx_chk.sv
// Structural invariants of gearbox_rx, attached to every instance via bind.
module gearbox_rx_chk
    import gearbox_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] cnt,
    input logic             header_ena
);

    logic ena_prev_r;

    // Fill level bound and no back-to-back block strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= 7'(BLOCK_W - 1))
                else $error("gearbox_rx cnt overflow: %0d", cnt);
            assert (!(header_ena && ena_prev_r))
                else $error("gearbox_rx header_ena back-to-back");
        end
        ena_prev_r <= rst ? 1'b0 : header_ena;
    end

endmodule

bind gearbox_rx gearbox_rx_chk u_gearbox_rx_chk (
    .clk        (clk),
    .rst        (rst),
    .cnt        (cnt_r),
    .header_ena (header_ena)
);

// File: rtl/gearbox_rx.sv
// 32->66 bit receive gearbox with bit slip for block alignment.
// Optional saturating slip counter: define GEARBOX_RX_SLIP_CNT_EN.
module gearbox_rx
    import gearbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   data_in,
    input  logic              data_in_ena,
    input  logic              slip,
    output logic [1:0]        header,
    output logic [63:0]       data,
    output logic              header_ena
`ifdef GEARBOX_RX_SLIP_CNT_EN
    ,
    output logic [SLIP_W-1:0] slip_cnt
`endif
);

    logic [BUF_W-1:0] buf_r;
    logic [CNT_W-1:0] cnt_r;
    logic             slip_hold_r;

    logic [BUF_W-1:0] in_ext_s;
    logic [BUF_W-1:0] comb_s;
    logic [BUF_W-1:0] slipped_s;
    logic [BUF_W-1:0] buf_next_s;
    logic [CNT_W-1:0] avail_s;
    logic [CNT_W-1:0] left_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             slip_req_s;
    logic             slip_apply_s;
    logic             emit_s;

    // Merge new bits above the valid fill, apply a pending slip, then extract.
    always_comb begin
        in_ext_s = BUF_W'(data_in);
        if (data_in_ena) begin
            comb_s  = buf_r | (in_ext_s << cnt_r);
            avail_s = cnt_r + 7'(IN_W);
        end else begin
            comb_s  = buf_r;
            avail_s = cnt_r;
        end
        // Bits above avail are always zero, so shifting never injects stale data.
        slip_req_s   = slip | slip_hold_r;
        slip_apply_s = slip_req_s && (avail_s != 7'd0);
        slipped_s    = slip_apply_s ? (comb_s >> 1) : comb_s;
        left_s       = slip_apply_s ? (avail_s - 7'd1) : avail_s;
        emit_s       = (left_s >= 7'(BLOCK_W));
        buf_next_s   = emit_s ? (slipped_s >> BLOCK_W) : slipped_s;
        cnt_next_s   = emit_s ? (left_s - 7'(BLOCK_W)) : left_s;
    end

    // State and registered block outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r       <= '0;
            cnt_r       <= 7'd0;
            slip_hold_r <= 1'b0;
            header      <= 2'b00;
            data        <= 64'd0;
            header_ena  <= 1'b0;
`ifdef GEARBOX_RX_SLIP_CNT_EN
            slip_cnt    <= 16'd0;
`endif
        end else begin
            buf_r       <= buf_next_s;
            cnt_r       <= cnt_next_s;
            slip_hold_r <= slip_req_s && !slip_apply_s;
            header_ena  <= emit_s;
            if (emit_s) begin
                header <= slipped_s[1:0];
                data   <= slipped_s[BLOCK_W-1:2];
            end
`ifdef GEARBOX_RX_SLIP_CNT_EN
            if (slip_apply_s) begin
                slip_cnt <= sat_inc16(slip_cnt);
            end
`endif
        end
    end

endmodule

// File: tb/tb_gearbox_rx.sv
// Directed bench for gearbox_rx with a bit-serial reference queue.
module tb_gearbox_rx;
    import gearbox_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'd0;
    logic        data_in_ena = 1'b0;
    logic        slip = 1'b0;
    logic [1:0]  header;
    logic [63:0] data;
    logic        header_ena;
`ifdef GEARBOX_RX_SLIP_CNT_EN
    logic [15:0] slip_cnt;
`endif

    always #5 clk = ~clk;

    gearbox_rx dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_in_ena (data_in_ena),
        .slip        (slip),
        .header      (header),
        .data        (data),
        .header_ena  (header_ena)
`ifdef GEARBOX_RX_SLIP_CNT_EN
        ,
        .slip_cnt    (slip_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    bit          mq[$];
    bit          mpend = 1'b0;
    logic        m_ena = 1'b0;
    logic [1:0]  m_hdr = 2'b00;
    logic [63:0] m_data = 64'd0;
    logic [15:0] m_slips = 16'd0;
    logic        prev_ena = 1'b0;
    bit          txq[$];
    logic [65:0] got[$];
    int          got_cyc[$];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] mkblk(input int k);
        return {32'hA5A5_0000 | 32'(k), 32'h1234_5678 ^ 32'(k), 2'b01};
    endfunction

    task automatic push_bits(input logic [65:0] v, input int n);
        for (int i = 0; i < n; i++) txq.push_back(v[i]);
    endtask

    task automatic tick(input logic r, input logic e, input logic s, input logic [31:0] d);
        logic [65:0] blk;
        rst = r; data_in_ena = e; slip = s; data_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            mpend = 1'b0; m_ena = 1'b0; m_hdr = 2'b00; m_data = 64'd0; m_slips = 16'd0;
        end else begin
            if (e) for (int i = 0; i < 32; i++) mq.push_back(d[i]);
            if (s || mpend) begin
                if (mq.size() > 0) begin
                    void'(mq.pop_front());
                    mpend = 1'b0;
                    if (m_slips != 16'hFFFF) m_slips = m_slips + 16'd1;
                end else begin
                    mpend = 1'b1;
                end
            end
            m_ena = 1'b0;
            if (mq.size() >= 66) begin
                for (int i = 0; i < 66; i++) blk[i] = mq.pop_front();
                m_hdr = blk[1:0]; m_data = blk[65:2]; m_ena = 1'b1;
            end
        end
        chk("header_ena", header_ena, m_ena);
        chk("header", header, m_hdr);
        chk("data", data, m_data);
        chk("b2b", header_ena & prev_ena, 1'b0);
`ifdef GEARBOX_RX_SLIP_CNT_EN
        chk("slip_cnt", slip_cnt, m_slips);
`endif
        prev_ena = header_ena;
        if (header_ena) begin
            got.push_back({data, header});
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic feed(input logic e, input logic s);
        logic [31:0] w;
        w = 32'd0;
        if (e) for (int i = 0; i < 32; i++) w[i] = (txq.size() > 0) ? txq.pop_front() : 1'b0;
        tick(1'b0, e, s, w);
    endtask

    initial begin
        logic [31:0] w0, w1, w2;
        logic [65:0] ref_blk;
        int aligned;

        // Reset, with slip/ena asserted during reset being ignored.
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("rst_cnt", dut.cnt_r, 7'd0);
        chk("rst_hdr", header, 2'b00);
        chk("rst_data", data, 64'd0);
        chk("rst_ena", header_ena, 1'b0);

        // 16 blocks in 33 continuous cycles.
        got.delete();
        for (int k = 0; k < 16; k++) push_bits(mkblk(k), 66);
        for (int i = 0; i < 33; i++) feed(1'b1, 1'b0);
        chk("n_blocks", got.size(), 16);
        for (int k = 0; k < 16; k++) begin
            ref_blk = mkblk(k);
            chk("blk_hdr", got[k][1:0], ref_blk[1:0]);
            chk("blk_data", got[k][65:2], ref_blk[65:2]);
        end
        chk("cnt_wrap", dut.cnt_r, 7'd0);

        // Slip with an empty buffer is held until data arrives.
        tick(1'b0, 1'b0, 1'b1, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("held_cnt", dut.cnt_r, 7'd31);
        chk("held_drop", dut.buf_r[31:0], 32'h6F56_DF77);
`ifdef GEARBOX_RX_SLIP_CNT_EN
        chk("held_slips", slip_cnt, 16'd1);
`endif

        // Three slips while empty collapse into one.
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("absorb_cnt", dut.cnt_r, 7'd31);
        chk("absorb_drop", dut.buf_r[31:0], 32'h6F56_DF77);

        // Reset at cnt=40 discards buffered bits.
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 26; i++) tick(1'b0, 1'b1, 1'b0, $urandom());
        chk("cnt40", dut.cnt_r, 7'd40);
        tick(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        w0 = 32'h0123_4567; w1 = 32'h89AB_CDEF; w2 = 32'hFEDC_BA98;
        tick(1'b0, 1'b1, 1'b0, w0);
        chk("post_rst_ena1", header_ena, 1'b0);
        tick(1'b0, 1'b1, 1'b0, w1);
        chk("post_rst_ena2", header_ena, 1'b0);
        tick(1'b0, 1'b1, 1'b0, w2);
        chk("post_rst_ena3", header_ena, 1'b1);
        chk("post_rst_hdr", header, w0[1:0]);
        chk("post_rst_data", data, {w2[1:0], w1, w0[31:2]});
        chk("post_rst_cnt", dut.cnt_r, 7'd30);

        // Five junk bits, then aligned blocks; five spaced slips realign.
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        txq.delete(); got.delete(); got_cyc.delete();
        push_bits(66'h0D, 5);
        for (int k = 0; k < 20; k++) push_bits(mkblk(k), 66);
        cyc = 0;
        for (int i = 0; i < 42; i++) feed(1'b1, (i % 8 == 0) && (i < 40));
        aligned = 0;
        for (int n = 0; n < got.size(); n++) begin
            if (got_cyc[n] >= 32 && n < 20) begin
                ref_blk = mkblk(n);
                chk("align_hdr", got[n][1:0], 2'(HDR_DATA));
                chk("align_data", got[n][65:2], ref_blk[65:2]);
                aligned++;
            end
        end
        chk("aligned_cnt", aligned, 5);
`ifdef GEARBOX_RX_SLIP_CNT_EN
        chk("align_slips", slip_cnt, 16'd5);
`endif

        // Random enable duty with occasional slips against the serial model.
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 200; i++)
            tick(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
